// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, fixed-latency unified memory between instruction
// fetch (IF) and data access (MEM). A data access wins over a fetch in the same
// cycle because it belongs to the older instruction. Each access holds address,
// write data and strobe stable for MEM_LATENCY cycles. The read data is sampled
// on the last of those cycles into the inst / data_in holding registers.
//
// While any request of the current pipeline step is still unserved, stall is
// high. It freezes the PC and all pipeline registers, so the requests stay
// asserted. The done flags make sure each request is issued only once per
// pipeline step.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   if_req, inst_adr         fetch request and PC
//   inst                     fetched instruction (registered)
//   mem_read, mem_write      MEM-stage load / store request
//   data_adr, data_out       load/store address, store data
//   data_in                  load data (registered)
//   stall                    freeze PC and pipeline registers this cycle
//   m_adr, m_wdata           memory address / write data (registered)
//   m_re, m_we               memory read / write strobes (registered)
//   m_rdata                  memory read data, valid on last access cycle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,   // cycles per access, 1..15
    parameter int CNT_W       = 4    // latency counter width
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] inst_adr,
    output logic [31:0] inst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] data_adr,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    output logic        stall,
    output logic [31:0] m_adr,
    output logic [31:0] m_wdata,
    output logic        m_re,
    output logic        m_we,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_D,
        BUSY_I
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             d_done;
    logic             i_done;
    logic             d_pend;
    logic             i_pend;

    // A request is pending until its access has completed in this pipeline step.
    assign d_pend = (mem_read | mem_write) & ~d_done;
    assign i_pend = if_req & ~i_done;
    assign stall  = d_pend | i_pend;

    // NOTE: all state below is sequential and uses non-blocking assignments
    // only, so every branch reads the pre-edge values of state, cnt and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            d_done  <= 1'b0;
            i_done  <= 1'b0;
            inst    <= '0;
            data_in <= '0;
            m_re    <= 1'b0;
            m_we    <= 1'b0;
            m_adr   <= '0;
            m_wdata <= '0;
        end else begin
            // The pipeline advances on every unstalled edge. The next step's
            // requests must then be served afresh.
            if (!stall) begin
                d_done <= 1'b0;
                i_done <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= CNT_LOAD;
                    if (d_pend) begin
                        state   <= BUSY_D;
                        m_adr   <= data_adr;
                        m_wdata <= data_out;
                        // Read and write together is illegal; the write wins.
                        m_we    <= mem_write;
                        m_re    <= mem_read & ~mem_write;
                    end else if (i_pend) begin
                        state <= BUSY_I;
                        m_adr <= inst_adr;
                        m_re  <= 1'b1;
                        m_we  <= 1'b0;
                    end
                end

                BUSY_D: begin
                    if (cnt == '0) begin
                        // m_re still reflects the granted access type.
                        if (m_re) begin
                            data_in <= m_rdata;
                        end
                        d_done <= 1'b1;
                        state  <= IDLE;
                        m_re   <= 1'b0;
                        m_we   <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                BUSY_I: begin
                    if (cnt == '0) begin
                        inst   <= m_rdata;
                        i_done <= 1'b1;
                        state  <= IDLE;
                        m_re   <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    m_re  <= 1'b0;
                    m_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the pipeline's instruction fetch (IF) and data access (MEM) stages.
- Grants data accesses first, since they belong to the older instruction.
- Sequences each access over MEM_LATENCY cycles and returns the fetched instruction and load data in holding registers.
- Drives a global stall that freezes the PC and all pipeline registers until every pending request of the current cycle is served.

Parameters:
MEM_LATENCY, 2, cycles the memory needs per access (address held stable); legal range 1..15
CNT_W, 4, width of the latency counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
if_req  input  1  fetch requested this cycle (PC valid)
inst_adr  input  32  fetch address (PC)
inst  output  32  fetched instruction, registered
mem_read  input  1  MEM-stage load request
mem_write  input  1  MEM-stage store request
data_adr  input  32  load/store address
data_out  input  32  store data from datapath
data_in  output  32  load data to datapath, registered
stall  output  1  freeze PC and pipeline registers this cycle
m_adr  output  32  memory address
m_wdata  output  32  memory write data
m_re  output  1  memory read strobe
m_we  output  1  memory write strobe
m_rdata  input  32  memory read data, valid on last cycle of an access

Behaviour:
- Reset: synchronous; state=IDLE, cnt=0, d_done=i_done=0, inst=0, data_in=0, m_re=m_we=0, m_adr=m_wdata=0. A reset mid-access abandons the access; nothing is captured.
- Pending requests:
  - d_pend = (mem_read|mem_write) & ~d_done.
  - i_pend = if_req & ~i_done.
- Stall: stall = d_pend | i_pend, combinational from registered flags, state and inputs.
- FSM states: IDLE, BUSY_D, BUSY_I.
  - IDLE: if d_pend, go to BUSY_D. Else if i_pend, go to BUSY_I. Else stay. Set cnt=MEM_LATENCY-1 on entry. Latch m_adr and m_wdata from data_adr/data_out (BUSY_D) or inst_adr (BUSY_I).
  - BUSY_D:
    - Drive m_we=mem_write and m_re=mem_read&~mem_write; both are registered and held for the whole state.
    - Decrement cnt each cycle.
    - When cnt==0: if a read, data_in<=m_rdata; set d_done=1; go to IDLE.
  - BUSY_I: drive m_re=1. When cnt==0: inst<=m_rdata; set i_done=1; go to IDLE.
- Latency:
  - A request first seen in IDLE at cycle t occupies the memory in cycles t+1..t+MEM_LATENCY.
  - Its done flag is visible in cycle t+MEM_LATENCY+1.
  - A fetch with no data access therefore stalls for MEM_LATENCY+1 cycles.
- Ordering within one stall window: the data access completes, then a single IDLE cycle, then the fetch. Worst case is 2*(MEM_LATENCY+1) stalled cycles.
- Done-flag clearing:
  - At any edge where stall==0, the pipeline advances, and d_done and i_done both clear.
  - A request therefore issues exactly once per pipeline step, even though it stays asserted while stalled.
- No request (if_req=mem_read=mem_write=0): stall=0 and the FSM stays in IDLE.
- mem_read and mem_write together is illegal. The write wins: m_we=1, m_re=0, and data_in is unchanged.
- inst and data_in hold their value until the next completing access of their type.
- Requests arriving during BUSY are not granted until the FSM returns to IDLE. Input changes during BUSY do not affect m_adr, m_wdata, m_re or m_we.
- MEM_LATENCY=1: each BUSY state lasts exactly one cycle.

Test Plan:
- Reset, MEM_LATENCY=2: hold rst 1 cycle with if_req=1 → after release, inst=0, data_in=0, m_re=m_we=0. Fetch then begins; stall=1 in the first cycle after reset.
- Fetch only: inst_adr=0x40, m_rdata=0x8C220004 → m_re=1 and m_adr=0x40 for 2 cycles. inst=0x8C220004 in cycle 4. stall=1 in cycles 1–3, 0 in cycle 4; i_done clears after that edge.
- Load + fetch together: mem_read=1, data_adr=0x100, memory returns 0x1234 for the data access → data access in cycles 2–3, fetch in cycles 5–6. data_in=0x1234, stall=1 for 6 cycles, exactly one m_re burst per address.
- Store: mem_write=1, data_adr=0x8, data_out=0xDEADBEEF → m_we=1 with m_adr=0x8 and m_wdata=0xDEADBEEF for exactly 2 cycles. data_in unchanged, m_re=0.
- Reset mid-access: assert rst in the second BUSY_I cycle → next cycle state=IDLE, m_re=0, inst stays at its previous value (0 after reset).
- Illegal mem_read=mem_write=1, data_adr=0x20 → write performed (m_we=1, m_re=0), data_in unchanged. Repeat with MEM_LATENCY=1: each access holds its strobe for 1 cycle, and a lone fetch stalls for 2 cycles.
